// File: rtl/sort_job_scheduler_pkg.sv
// sort_sched_pkg: shared state type and helpers for the sort job scheduler
package sort_sched_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT, DRAIN} sched_state_t;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/sort_job_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant searching from ptr+1, wrapping
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);
  function automatic logic [ID_W-1:0] wrap(input logic [ID_W-1:0] p, input int k);
    return ID_W'((int'(p) + k) % NUM_REQ);
  endfunction
  // scan farthest-first so the nearest requester after ptr wins the overwrite
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req[wrap(ptr, k)]) begin
        gnt = NUM_REQ'(1) << wrap(ptr, k);
        gnt_id = wrap(ptr, k);
      end
  end
endmodule

// File: rtl/sort_job_scheduler.sv
// sort_job_scheduler: arbitrates jobs onto one sort engine and streams results back
module sort_job_scheduler
  import sort_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 1024,
  localparam int IDX_W = $clog2(ARRAY_SIZE),
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ARRAY_SIZE*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [ARRAY_SIZE*DATA_W-1:0]   eng_load_data,
  output logic                           eng_start,
  input  logic                           eng_done,
  output logic                           eng_abort,
  output logic [IDX_W-1:0]               eng_rd_idx,
  input  logic [DATA_W-1:0]              eng_rd_data,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [DATA_W-1:0]              res_data,
  output logic [IDX_W-1:0]               res_idx,
  output logic [ID_W-1:0]                res_id,
  output logic                           res_last,
  output logic                           err_timeout,
  output logic [ID_W-1:0]                err_id,
  output logic                           busy
);
  localparam int CNT_W = $clog2(max_int(TIMEOUT, ARRAY_SIZE));
  localparam int SLICE_W = ARRAY_SIZE * DATA_W;
  sched_state_t state;
  logic [ID_W-1:0] rr_ptr, id, gnt_id;
  logic [NUM_REQ-1:0] gnt;
  logic [CNT_W-1:0] cnt;
  logic done_q, drain;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(gnt),
    .gnt_id(gnt_id)
  );
  assign drain = state == DRAIN;
  // result port reads the engine directly so a stalled beat stays put while cnt holds
  always_comb begin
    req_ready = state == IDLE ? gnt : '0;
    busy = state != IDLE;
    res_valid = drain;
    eng_rd_idx = drain ? IDX_W'(cnt) : '0;
    res_idx = eng_rd_idx;
    res_data = drain ? eng_rd_data : '0;
    res_id = drain ? id : '0;
    res_last = drain && cnt == CNT_W'(ARRAY_SIZE - 1);
  end
  // job sequencing: grant, start pulse, edge-qualified wait with timeout, drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      id <= '0;
      cnt <= '0;
      done_q <= 1'b0;
      eng_load_data <= '0;
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      err_timeout <= 1'b0;
      err_id <= '0;
    end else begin
      done_q <= eng_done;
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: if (|req_ready) begin
          eng_load_data <= req_data[int'(gnt_id) * SLICE_W +: SLICE_W];
          id <= gnt_id;
          rr_ptr <= gnt_id;
          eng_start <= 1'b1;
          state <= START;
        end
        START: begin
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: if (eng_done && !done_q) begin
          cnt <= '0;
          state <= DRAIN;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          eng_abort <= 1'b1;
          err_timeout <= 1'b1;
          err_id <= id;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        DRAIN: if (res_ready) begin
          cnt <= cnt + 1'b1;
          if (res_last) state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sort_job_scheduler.sv
// tb_sort_job_scheduler: randomized scoreboard bench with a behavioural sort engine
module tb_sort_job_scheduler;
  localparam int N = 4, ASZ = 8, DW = 32, TO = 16;
  typedef struct packed {logic [DW-1:0] data; logic [2:0] idx; logic [1:0] id; logic last;} beat_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*ASZ*DW-1:0] req_data;
  logic [ASZ*DW-1:0] eng_load_data;
  logic eng_start, eng_done, eng_abort, res_valid, res_ready = 1'b1, res_last, err_timeout, busy;
  logic [2:0] eng_rd_idx, res_idx;
  logic [DW-1:0] eng_rd_data, res_data;
  logic [1:0] res_id, err_id;
  logic [DW-1:0] arr [N][ASZ];
  logic [DW-1:0] plan1 [ASZ] = '{23, 5, 17, 9, 1, 12, 3, 8};
  beat_t sb[$];
  int exp_abort[$];
  int checks = 0, errors = 0, cyc = 0, grant_cnt = 0, done_jobs = 0, starts = 0;
  int beat_cnt = 0, start_cyc = 0, last_gnt = 0, rr_mode = 0, ph = 0, g, a, bound;
  logic eng_hang = 1'b0, eng_stale = 1'b0, eng_kill = 1'b0, prev_stall = 1'b0, prev_start = 1'b0;
  logic [38:0] prev_beat;
  logic [DW-1:0] eng_sorted [ASZ];
  logic eng_done_r;
  int eng_lat;

  always #5 clk = ~clk;

  sort_job_scheduler #(.NUM_REQ(N), .ARRAY_SIZE(ASZ), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .eng_load_data(eng_load_data), .eng_start(eng_start), .eng_done(eng_done),
    .eng_abort(eng_abort), .eng_rd_idx(eng_rd_idx), .eng_rd_data(eng_rd_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
    .res_id(res_id), .res_last(res_last), .err_timeout(err_timeout), .err_id(err_id), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] kth(input logic [ASZ*DW-1:0] v, input int k);
    logic [DW-1:0] q[$];
    for (int j = 0; j < ASZ; j++) q.push_back(v[j*DW +: DW]);
    q.sort();
    return q[k];
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < ASZ; j++) req_data[(i*ASZ + j)*DW +: DW] = arr[i][j];
  end

  // behavioural engine: sorts on start, raises done after a random latency
  always @(posedge clk)
    if (eng_start) for (int j = 0; j < ASZ; j++) eng_sorted[j] <= kth(eng_load_data, j);
  always @(posedge clk or posedge rst)
    if (rst) begin
      eng_done_r <= 1'b0;
      eng_lat <= 0;
    end else if (eng_start) begin
      eng_done_r <= 1'b0;
      eng_lat <= $urandom_range(2, 7);
    end else if (eng_abort) begin
      eng_done_r <= 1'b0;
      eng_lat <= 0;
    end else if (eng_lat == 1) begin
      eng_lat <= 0;
      eng_done_r <= !eng_hang;
    end else if (eng_lat != 0) eng_lat <= eng_lat - 1;
  assign eng_done = eng_stale | (eng_done_r & ~eng_kill);
  assign eng_rd_data = eng_sorted[eng_rd_idx];

  // result consumer: always ready, 1-0-0-1 backpressure, or random
  initial forever begin
    @(posedge clk);
    #1;
    res_ready = rr_mode == 0 ? 1'b1 : rr_mode == 1 ? (ph % 4 == 0 || ph % 4 == 3) : 1'($urandom_range(0, 1));
    ph++;
  end

  // monitor: grant prediction, scoreboard pops, stall stability, timeout timing
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (eng_start) begin
        chk("start_single_cycle", prev_start, 0);
        starts++;
        start_cyc = cyc;
        beat_cnt = 0;
      end
      prev_start = eng_start;
      if (eng_abort || err_timeout) chk("abort_pair", err_timeout, eng_abort);
      if (eng_abort) begin
        if (exp_abort.size() == 0) chk("unexpected_abort", 1, 0);
        else begin
          a = exp_abort.pop_front();
          chk("err_id", err_id, a);
          chk("abort_latency", cyc - start_cyc, 17);
        end
        done_jobs++;
      end
      if (prev_stall) chk("stall_hold", {res_valid, res_data, res_idx, res_id, res_last}, prev_beat);
      if (res_valid && res_ready) begin
        if (sb.size() == 0) chk("unexpected_beat", 1, 0);
        else chk("beat", {res_data, res_idx, res_id, res_last}, sb.pop_front());
        beat_cnt++;
        if (res_last) done_jobs++;
      end
      prev_stall = res_valid && !res_ready;
      prev_beat = {res_valid, res_data, res_idx, res_id, res_last};
      if (busy) chk("ready_while_busy", req_ready, 0);
      else begin
        g = pick(req_valid, last_gnt);
        chk("grant", req_ready, g < 0 ? 0 : 1 << g);
        if (g >= 0) begin
          last_gnt = g;
          grant_cnt++;
          if (eng_hang) exp_abort.push_back(g);
          else for (int k = 0; k < ASZ; k++)
            sb.push_back('{kth(req_data[g*ASZ*DW +: ASZ*DW], k), 3'(k), 2'(g), k == ASZ - 1});
        end
      end
    end
  end

  task automatic wait_grants(input int n);
    int c = 0;
    while (grant_cnt < n && c < 200) begin
      @(negedge clk);
      #1;
      c++;
    end
    if (grant_cnt < n) chk("grant_wait", grant_cnt, n);
  endtask

  task automatic wait_jobs(input int n);
    int c = 0;
    while (done_jobs < n && c < 400) begin
      @(negedge clk);
      #1;
      c++;
    end
    if (done_jobs < n) chk("job_wait", done_jobs, n);
  endtask

  task automatic one_job(input logic [N-1:0] v);
    int t = grant_cnt + 1;
    @(posedge clk);
    #1;
    req_valid = v;
    wait_grants(t);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_jobs(t);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_idx"}, res_idx, 0);
    chk({tag, "_res_id"}, res_id, 0);
    chk({tag, "_res_last"}, res_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_eng_start"}, eng_start, 0);
    chk({tag, "_eng_abort"}, eng_abort, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
    chk({tag, "_err_id"}, err_id, 0);
    chk({tag, "_load_data"}, |eng_load_data, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rd_idx"}, eng_rd_idx, 0);
  endtask

  task automatic rand_rows();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < ASZ; j++) arr[i][j] = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 7);
  endtask

  initial begin
    rand_rows();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < ASZ; j++) arr[0][j] = plan1[j];
    one_job(4'b0001);
    chk("one_start_per_job", starts, grant_cnt);
    rand_rows();
    rr_mode = 1;
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    wait_grants(grant_cnt + 5);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_jobs(grant_cnt);
    rr_mode = 0;
    eng_hang = 1'b1;
    one_job(4'b0100);
    eng_hang = 1'b0;
    one_job(4'b0100);
    eng_stale = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 4'b1000;
    wait_grants(grant_cnt + 1);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (10) begin
      @(negedge clk);
      chk("stale_no_drain", res_valid, 0);
    end
    @(posedge clk);
    #1;
    eng_stale = 1'b0;
    eng_kill = 1'b1;
    @(posedge clk);
    #1;
    eng_kill = 1'b0;
    wait_jobs(grant_cnt);
    rr_mode = 2;
    bound = 0;
    a = done_jobs + 40;
    while (done_jobs < a && bound < 4000) begin
      @(posedge clk);
      #1;
      req_valid = N'($urandom);
      if (busy) rand_rows();
      bound++;
    end
    req_valid = '0;
    wait_jobs(grant_cnt);
    rr_mode = 0;
    rand_rows();
    @(posedge clk);
    #1;
    req_valid = 4'b0001;
    wait_grants(grant_cnt + 1);
    @(posedge clk);
    #1;
    req_valid = '0;
    bound = 0;
    while (beat_cnt < 3 && bound < 100) begin
      @(negedge clk);
      #1;
      bound++;
    end
    chk("reached_beat3", beat_cnt >= 3, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero("mid_reset");
    sb.delete();
    exp_abort.delete();
    last_gnt = 0;
    done_jobs = grant_cnt;
    @(negedge clk);
    rst = 1'b0;
    one_job(4'b0001);
    one_job(4'b1111);
    chk("scoreboard_empty", sb.size(), 0);
    chk("aborts_empty", exp_abort.size(), 0);
    chk("starts_match_grants", starts, grant_cnt);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
